// File: rtl/alu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alu_pkg : opcode/state types and decode helpers for alu_pipe     |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_SLT  = 4'd8,
    OP_SLTU = 4'd9,
    OP_DIV  = 4'd10,
    OP_DIVU = 4'd11,
    OP_REM  = 4'd12,
    OP_REMU = 4'd13
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } alu_state_e;

  function automatic logic is_div_op(input alu_op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic is_signed_op(input alu_op_e op);
    return op inside {OP_DIV, OP_REM};
  endfunction

  function automatic logic is_rem_op(input alu_op_e op);
    return op inside {OP_REM, OP_REMU};
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alu_if : request/result handshake bundle for alu_pipe            |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
interface alu_if #(
  parameter int XLEN = 32
);
  import alu_pkg::*;

  logic            in_valid;
  logic            in_ready;
  alu_op_e         op;
  logic [XLEN-1:0] d1;
  logic [XLEN-1:0] d2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] alu_output;
  logic            zero;
  logic            last_bit;
  logic            illegal;

  modport master (
    output in_valid, op, d1, d2, out_ready,
    input  in_ready, out_valid, alu_output, zero, last_bit, illegal
  );

  modport slave (
    input  in_valid, op, d1, d2, out_ready,
    output in_ready, out_valid, alu_output, zero, last_bit, illegal
  );

endinterface
`default_nettype wire

// File: rtl/alu_div_iter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alu_div_iter : restoring unsigned divider, one bit per cycle     |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
module alu_div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int CW = $clog2(XLEN) + 1;

  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN:0]   partial;
  logic [XLEN:0]   trial;

  always_comb begin
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    partial = {rem_q, quo_q[XLEN-1]};
    trial   = partial - {1'b0, dvs_q};
    if (start) begin
      quo_d = dividend;
      rem_d = '0;
      dvs_d = divisor;
      cnt_d = CW'(XLEN);
    end else if (cnt_q != '0) begin
      // a borrow out of the trial subtraction means the divisor did not fit
      quo_d = {quo_q[XLEN-2:0], ~trial[XLEN]};
      rem_d = trial[XLEN] ? partial[XLEN-1:0] : trial[XLEN-1:0];
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
    end
  end

  // Drops one cycle early so the caller's FSM leaves its wait state as the final bit lands.
  assign busy      = (cnt_q > CW'(1));
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alu_pipe : RV32I ALU with registered, handshaked result.         |
// | ALU_DIV_EN adds an iterative DIV/DIVU/REM/REMU unit.             |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
module alu_pipe
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic clk,
  input  logic rst,
  alu_if.slave bus
);

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] alu_res;
  logic            accept;
  logic            op_illegal;
  logic            wr_en;
  logic            wr_illegal;
  logic [XLEN-1:0] wr_data;

  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic            last_bit_q, last_bit_d;
  logic            illegal_q, illegal_d;

  assign shamt  = bus.d2[SHW-1:0];
  assign accept = bus.in_valid && bus.in_ready;

  always_comb begin
    alu_res = '0;
    case (bus.op)
      OP_ADD:  alu_res = bus.d1 + bus.d2;
      OP_SUB:  alu_res = bus.d1 + ~bus.d2 + XLEN'(1);
      OP_AND:  alu_res = bus.d1 & bus.d2;
      OP_OR:   alu_res = bus.d1 | bus.d2;
      OP_XOR:  alu_res = bus.d1 ^ bus.d2;
      OP_SLL:  alu_res = bus.d1 << shamt;
      OP_SRL:  alu_res = bus.d1 >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(bus.d1) >>> shamt);
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(bus.d1) < $signed(bus.d2))};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (bus.d1 < bus.d2)};
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_DIV_EN
  localparam logic [XLEN-1:0] c_min  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] c_ones = '1;

  alu_state_e      state_q, state_d;
  logic            div_start, div_busy, div_zero, div_ovf;
  logic            neg_a, neg_b;
  logic            q_neg_q, q_neg_d, r_neg_q, r_neg_d, rem_sel_q, rem_sel_d;
  logic [XLEN-1:0] mag_a, mag_b, quotient, remainder, div_result;

  assign op_illegal   = (bus.op > OP_REMU);
  assign div_zero     = is_div_op(bus.op) && (bus.d2 == '0);
  assign div_ovf      = is_signed_op(bus.op) && (bus.d1 == c_min) && (bus.d2 == c_ones);
  assign neg_a        = is_signed_op(bus.op) && bus.d1[XLEN-1];
  assign neg_b        = is_signed_op(bus.op) && bus.d2[XLEN-1];
  assign mag_a        = neg_a ? -bus.d1 : bus.d1;
  assign mag_b        = neg_b ? -bus.d2 : bus.d2;
  assign bus.in_ready = (state_q == IDLE) && (!out_valid_q || bus.out_ready);

  alu_div_iter #(
    .XLEN (XLEN)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .busy      (div_busy),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (div_start) state_d = DIV;
      DIV:     if (!div_busy) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sign fix-up: quotient negative when signs differ, remainder follows the dividend.
  always_comb begin
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    rem_sel_d = rem_sel_q;
    if (div_start) begin
      q_neg_d   = neg_a ^ neg_b;
      r_neg_d   = neg_a;
      rem_sel_d = is_rem_op(bus.op);
    end
    div_result = rem_sel_q ? (r_neg_q ? -remainder : remainder)
                           : (q_neg_q ? -quotient  : quotient);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      rem_sel_q <= 1'b0;
    end else begin
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      rem_sel_q <= rem_sel_d;
    end
  end
`else
  assign op_illegal   = (bus.op > OP_SLTU);
  assign bus.in_ready = !out_valid_q || bus.out_ready;
`endif

  always_comb begin
    wr_en      = 1'b0;
    wr_illegal = 1'b0;
    wr_data    = '0;
`ifdef ALU_DIV_EN
    div_start  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (op_illegal) begin
            wr_en      = 1'b1;
            wr_illegal = 1'b1;
          end else if (div_zero) begin
            wr_en   = 1'b1;
            wr_data = is_rem_op(bus.op) ? bus.d1 : c_ones;
          end else if (div_ovf) begin
            wr_en   = 1'b1;
            wr_data = is_rem_op(bus.op) ? '0 : c_min;
          end else if (is_div_op(bus.op)) begin
            div_start = 1'b1;
          end else begin
            wr_en   = 1'b1;
            wr_data = alu_res;
          end
        end
      end
      DONE: begin
        wr_en   = 1'b1;
        wr_data = div_result;
      end
      default: ;
    endcase
`else
    if (accept) begin
      wr_en      = 1'b1;
      wr_illegal = op_illegal;
      wr_data    = op_illegal ? '0 : alu_res;
    end
`endif
  end

  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    last_bit_d  = last_bit_q;
    illegal_d   = illegal_q;
    if (wr_en) begin
      out_valid_d = 1'b1;
      result_d    = wr_data;
      zero_d      = (wr_data == '0);
      last_bit_d  = wr_data[XLEN-1];
      illegal_d   = wr_illegal;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      last_bit_q  <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      last_bit_q  <= last_bit_d;
      illegal_q   <= illegal_d;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.alu_output = result_q;
  assign bus.zero       = zero_q;
  assign bus.last_bit   = last_bit_q;
  assign bus.illegal    = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_alu_pipe : self-checking bench for alu_pipe (XLEN=32)         |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int XLEN = 32;
`ifdef ALU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  alu_if #(.XLEN(XLEN)) bus ();

  alu_pipe #(.XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  // Reference: result, illegal flag and number of cycles in_ready stays low after acceptance.
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] res, output logic ill, output int busy);
    longint      sa, sb;
    int unsigned sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = b[4:0];
    res = 32'h0; ill = 1'b0; busy = 0;
    case (op)
      4'd0: res = a + b;
      4'd1: res = a - b;
      4'd2: res = a & b;
      4'd3: res = a | b;
      4'd4: res = a ^ b;
      4'd5: res = a << sh;
      4'd6: res = a >> sh;
      4'd7: res = 32'(sa >>> sh);
      4'd8: res = (sa < sb) ? 32'd1 : 32'd0;
      4'd9: res = (a < b) ? 32'd1 : 32'd0;
      4'd10, 4'd11, 4'd12, 4'd13: begin
        if (!DIV_EN) ill = 1'b1;
        else if (b == 32'h0) res = (op >= 4'd12) ? a : 32'hFFFFFFFF;
        else if ((op == 4'd10 || op == 4'd12) && a == 32'h80000000 && b == 32'hFFFFFFFF)
          res = (op == 4'd10) ? a : 32'h0;
        else begin
          busy = XLEN + 1;
          case (op)
            4'd10:   res = 32'(sa / sb);
            4'd11:   res = a / b;
            4'd12:   res = 32'(sa % sb);
            default: res = a % b;
          endcase
        end
      end
      default: ill = 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h80000000;
      2:       return 32'hFFFFFFFF;
      3:       return 32'($urandom_range(0, 20));
      4:       return -32'($urandom_range(1, 20));
      default: return $urandom();
    endcase
  endfunction

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic rdy);
    bus.in_valid = 1'b1;
    bus.op       = alu_op_e'(op);
    bus.d1       = a;
    bus.d2       = b;
    #1;
    rdy = bus.in_ready;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int gap, output int rdy_low, output bit tmo);
    gap = 0; rdy_low = 0; tmo = 1'b0;
    while (bus.out_valid !== 1'b1) begin
      gap++;
      if (bus.in_ready !== 1'b1) rdy_low++;
      if (gap > 200) begin tmo = 1'b1; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.op = OP_ADD; bus.d1 = '0; bus.d2 = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_checks++; if (bus.alu_output !== 32'h0) begin n_fail++; $display("FAIL reset_alu_output: got %h want 0", bus.alu_output); end
    n_checks++; if (bus.zero !== 1'b0) begin n_fail++; $display("FAIL reset_zero: got %b want 0", bus.zero); end
    n_checks++; if (bus.last_bit !== 1'b0) begin n_fail++; $display("FAIL reset_last_bit: got %b want 0", bus.last_bit); end
    n_checks++; if (bus.illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal: got %b want 0", bus.illegal); end
    rst = 1'b0;
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_add();
    logic rdy; int gap, rl; bit tmo;
    issue(4'd0, 32'h7FFFFFFF, 32'h1, rdy);
    wait_out(gap, rl, tmo);
    n_checks++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL add_ready: got %b want 1", rdy); end
    n_checks++; if (tmo || gap != 0) begin n_fail++; $display("FAIL add_latency: got gap %0d want 0", gap); end
    n_checks++; if (bus.alu_output !== 32'h80000000) begin n_fail++; $display("FAIL add_result: got %h want 80000000", bus.alu_output); end
    n_checks++; if (bus.last_bit !== 1'b1) begin n_fail++; $display("FAIL add_last_bit: got %b want 1", bus.last_bit); end
    n_checks++; if (bus.zero !== 1'b0) begin n_fail++; $display("FAIL add_zero: got %b want 0", bus.zero); end
  endtask

  task automatic test_back_to_back();
    bus.in_valid = 1'b1; bus.op = OP_SUB; bus.d1 = 32'd5; bus.d2 = 32'd5;
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready0: got %b want 1", bus.in_ready); end
    @(posedge clk); #1;
    n_checks++; if (bus.out_valid !== 1'b1 || bus.alu_output !== 32'h0) begin n_fail++; $display("FAIL b2b_sub: got v=%b %h want v=1 0", bus.out_valid, bus.alu_output); end
    n_checks++; if (bus.zero !== 1'b1) begin n_fail++; $display("FAIL b2b_sub_zero: got %b want 1", bus.zero); end
    bus.op = OP_SRA; bus.d1 = 32'h80000000; bus.d2 = 32'h21;
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready1: got %b want 1", bus.in_ready); end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b1 || bus.alu_output !== 32'hC0000000) begin n_fail++; $display("FAIL b2b_sra: got v=%b %h want v=1 c0000000", bus.out_valid, bus.alu_output); end
    n_checks++; if (bus.zero !== 1'b0 || bus.last_bit !== 1'b1) begin n_fail++; $display("FAIL b2b_sra_flags: got z=%b lb=%b want z=0 lb=1", bus.zero, bus.last_bit); end
  endtask

  task automatic test_div();
    logic [3:0]  ops [2] = '{4'd10, 4'd12};
    logic [31:0] exp [2] = '{32'hFFFFFFFD, 32'hFFFFFFFF};
    for (int i = 0; i < 2; i++) begin
      logic rdy; int gap, rl; bit tmo;
      logic [31:0] want;
      int          want_busy;
      want      = DIV_EN ? exp[i] : 32'h0;
      want_busy = DIV_EN ? XLEN + 1 : 0;
      issue(ops[i], -32'sd7, 32'd2, rdy);
      wait_out(gap, rl, tmo);
      n_checks++; if (tmo || gap != want_busy) begin n_fail++; $display("FAIL div%0d_latency: got gap %0d want %0d", i, gap, want_busy); end
      n_checks++; if (rl != want_busy) begin n_fail++; $display("FAIL div%0d_ready_low: got %0d want %0d", i, rl, want_busy); end
      n_checks++; if (bus.alu_output !== want) begin n_fail++; $display("FAIL div%0d_result: got %h want %h", i, bus.alu_output, want); end
      n_checks++; if (bus.illegal !== !DIV_EN) begin n_fail++; $display("FAIL div%0d_illegal: got %b want %b", i, bus.illegal, !DIV_EN); end
    end
  endtask

  task automatic test_div_fast();
    logic [3:0]  ops [3] = '{4'd11, 4'd10, 4'd12};
    logic [31:0] fa  [3] = '{32'd9, 32'h80000000, 32'h80000000};
    logic [31:0] fb  [3] = '{32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] exp [3] = '{32'hFFFFFFFF, 32'h80000000, 32'h0};
    for (int i = 0; i < 3; i++) begin
      logic rdy; int gap, rl; bit tmo;
      logic [31:0] want;
      want = DIV_EN ? exp[i] : 32'h0;
      issue(ops[i], fa[i], fb[i], rdy);
      wait_out(gap, rl, tmo);
      n_checks++; if (tmo || gap != 0) begin n_fail++; $display("FAIL fast%0d_latency: got gap %0d want 0", i, gap); end
      n_checks++; if (bus.alu_output !== want) begin n_fail++; $display("FAIL fast%0d_result: got %h want %h", i, bus.alu_output, want); end
    end
  endtask

  task automatic test_stall();
    logic rdy; int gap, rl; bit tmo;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    issue(4'd0, 32'd100, 32'd23, rdy);
    wait_out(gap, rl, tmo);
    n_checks++; if (tmo || bus.alu_output !== 32'd123) begin n_fail++; $display("FAIL stall_first: got %h want 0000007b", bus.alu_output); end
    bus.in_valid = 1'b1; bus.op = OP_SUB; bus.d1 = 32'd50; bus.d2 = 32'd8;
    #1;
    for (int c = 0; c < 5; c++) begin
      n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready c%0d: got %b want 0", c, bus.in_ready); end
      n_checks++; if (bus.out_valid !== 1'b1 || bus.alu_output !== 32'd123) begin n_fail++; $display("FAIL stall_hold c%0d: got v=%b %h want v=1 0000007b", c, bus.out_valid, bus.alu_output); end
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release_ready: got %b want 1", bus.in_ready); end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b1 || bus.alu_output !== 32'd42) begin n_fail++; $display("FAIL stall_next: got v=%b %h want v=1 0000002a", bus.out_valid, bus.alu_output); end
  endtask

  task automatic test_reset_mid_div();
    logic rdy; int gap, rl, seen; bit tmo;
    issue(4'd0, 32'h1234, 32'h1, rdy);
    wait_out(gap, rl, tmo);
    n_checks++; if (tmo || bus.alu_output !== 32'h1235) begin n_fail++; $display("FAIL rmd_pre: got %h want 00001235", bus.alu_output); end
    issue(4'd10, 32'd1000, 32'd7, rdy);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_checks++; if (bus.out_valid !== 1'b0 || bus.alu_output !== 32'h0) begin n_fail++; $display("FAIL rmd_async: got v=%b %h want v=0 0", bus.out_valid, bus.alu_output); end
    n_checks++; if (bus.illegal !== 1'b0 || bus.zero !== 1'b0) begin n_fail++; $display("FAIL rmd_flags: got ill=%b z=%b want 0 0", bus.illegal, bus.zero); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rmd_ready: got %b want 1", bus.in_ready); end
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) seen++;
    end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL rmd_stale: got %0d valid cycles want 0", seen); end
    issue(4'd14, 32'd5, 32'd6, rdy);
    wait_out(gap, rl, tmo);
    n_checks++; if (tmo || gap != 0) begin n_fail++; $display("FAIL illegal_latency: got gap %0d want 0", gap); end
    n_checks++; if (bus.illegal !== 1'b1 || bus.alu_output !== 32'h0 || bus.zero !== 1'b1) begin n_fail++; $display("FAIL illegal_out: got ill=%b %h z=%b want 1 0 1", bus.illegal, bus.alu_output, bus.zero); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 250; n++) begin
      logic [3:0]  op;
      logic [31:0] a, b, want;
      logic        ill, rdy;
      int          busy, gap, rl;
      bit          tmo;
      op = 4'($urandom_range(0, 15));
      a  = pick();
      b  = pick();
      model(op, a, b, want, ill, busy);
      issue(op, a, b, rdy);
      wait_out(gap, rl, tmo);
      n_checks++; if (tmo || gap != busy || rl != busy) begin n_fail++; $display("FAIL rnd%0d_timing op=%0d: got gap=%0d rlow=%0d want %0d", n, op, gap, rl, busy); end
      n_checks++; if (bus.alu_output !== want || bus.illegal !== ill) begin n_fail++; $display("FAIL rnd%0d_result op=%0d a=%h b=%h: got %h ill=%b want %h ill=%b", n, op, a, b, bus.alu_output, bus.illegal, want, ill); end
      n_checks++; if (bus.zero !== (want == 32'h0) || bus.last_bit !== want[31]) begin n_fail++; $display("FAIL rnd%0d_flags: got z=%b lb=%b want z=%b lb=%b", n, bus.zero, bus.last_bit, (want == 32'h0), want[31]); end
      if ($urandom_range(0, 3) == 0) begin
        bus.out_ready = 1'b0;
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk); #1;
          n_checks++; if (bus.out_valid !== 1'b1 || bus.alu_output !== want) begin n_fail++; $display("FAIL rnd%0d_hold: got v=%b %h want v=1 %h", n, bus.out_valid, bus.alu_output, want); end
        end
        bus.out_ready = 1'b1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_div();
    test_div_fast();
    test_stall();
    test_reset_mid_div();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, handshaked successor to the single-cycle RV32I ALU.
- Operand width is XLEN. Output is registered with valid/ready flow control.
- Covers the full RV32I ALU op set (add/sub/logic/shifts/compares) in 1 cycle.
- Optionally adds an iterative M-extension divider that takes XLEN cycles.
- Sits between decode/register-read and writeback; the core stalls on in_ready.

Parameters:
- XLEN, 32, operand/result width; power of two, 8..64.
- SHW, $clog2(XLEN), shift-amount width; derived, not overridden.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept a request this cycle
- op  in  4  alu_pkg::alu_op_e opcode
- d1  in  XLEN  operand A (rs1)
- d2  in  XLEN  operand B (rs2/imm)
- out_valid  out  1  result registered and held
- out_ready  in  1  consumer takes result
- alu_output  out  XLEN  result
- zero  out  1  alu_output == 0
- last_bit  out  1  alu_output[XLEN-1]
- illegal  out  1  op unsupported in this build; result forced 0

Behaviour:
- Reset:
  - Asynchronous: on rst assertion, out_valid, alu_output, zero, illegal go 0 immediately.
  - zero resets to 0 (it is qualified by out_valid). last_bit resets to 0.
  - FSM returns to IDLE. Any divide in progress is aborted with no output.
- Opcodes:
  - ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9.
  - DIV=10, DIVU=11, REM=12, REMU=13. Codes 14-15 are illegal.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^XLEN; SUB is two's-complement d1 + ~d2 + 1.
  - Shifts use d2[SHW-1:0] only; SRA sign-fills.
  - SLT/SLTU return 0 or 1, zero-extended.
- Handshake:
  - Request accepted on a cycle where in_valid && in_ready.
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - out_valid stays high, and all outputs stay stable, until out_valid && out_ready.
- FSM states IDLE, DIV, DONE:
  - IDLE, accepting a single-cycle op: outputs written; out_valid=1 next cycle (latency 1); stay IDLE.
  - IDLE, accepting DIV*/REM* with d2==0: fast path, latency 1. Quotient is all-ones; remainder is d1.
  - IDLE, accepting DIV/REM with d1==MIN and d2==-1: fast path, latency 1. Quotient is MIN; remainder is 0.
  - IDLE, accepting any other divide: go to DIV. Operands are latched as magnitudes; result sign flags are latched.
  - DIV: one quotient bit per cycle; exits after exactly XLEN cycles to DONE.
  - DONE: apply sign correction. Quotient is negated if operand signs differ; remainder takes d1's sign. Write outputs, set out_valid, go to IDLE.
  - Divide latency: out_valid rises XLEN+1 cycles after acceptance.
- Back-to-back:
  - A single-cycle op may be accepted on the same cycle a previous result is consumed. Full throughput: 1 op per cycle.
- Illegal op: latency 1, alu_output=0, illegal=1, zero=1.
- in_valid while !in_ready: ignored; the requester must hold the request.

Optional Feature:
- Macro: ALU_DIV_EN.
- Defined: DIV/DIVU/REM/REMU and the DIV/DONE states are built as described above.
- Undefined:
  - Opcodes 10-13 are treated as illegal (latency 1, result 0, illegal=1).
  - The divider sub-module and FSM states are not instantiated; the block is purely single-cycle with a registered output.

Decomposition:
- alu_pkg holds:
  - typedef enum logic [3:0] alu_op_e with the codes listed under Behaviour.
  - typedef enum alu_state_e {IDLE, DIV, DONE}.
  - localparam helper functions is_div_op() and is_signed_op().
- Sub-module alu_div_iter: restoring unsigned divider, XLEN iterations.
  - Ports: clk, rst, start, dividend, divisor, busy, quotient, remainder.
  - Instantiated only under ALU_DIV_EN.

Test Plan:
- ADD d1=0x7FFFFFFF, d2=1, out_ready=1 -> next cycle out_valid=1, alu_output=0x80000000, last_bit=1, zero=0.
- SUB d1=5, d2=5, then SRA d1=0x80000000, d2=0x21 -> results 0 (zero=1), then 0xC0000000 on consecutive cycles. Shift amount is 1; in_ready stays high throughout.
- DIV d1=-7, d2=2 (ALU_DIV_EN defined) -> in_ready=0 for 33 cycles, out_valid at acceptance+33, alu_output=0xFFFFFFFD. REM same operands -> 0xFFFFFFFF.
- DIVU d1=9, d2=0 -> latency 1, alu_output=0xFFFFFFFF. DIV d1=0x80000000, d2=-1 -> 0x80000000. REM of the same -> 0.
- Hold out_ready=0 for 5 cycles after an ADD result -> alu_output stable and in_ready=0 throughout. A new request is accepted on the cycle out_ready rises.
- Assert rst mid-DIV (cycle 10) -> outputs 0 immediately. After release, in_ready=1 and no stale out_valid appears. Op 14 then gives illegal=1, alu_output=0.
